// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit with redirect flush,
// misaligned-target detection and response timeout recovery.
module instr_fetch #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned IMEM_MAX_LAT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   output logic        fetch_err
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = $clog2(IMEM_MAX_LAT + 2);
   localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]   instr_q, instr_d;
   logic [XLEN-1:0]   instr_pc_q, instr_pc_d;
   logic              instr_valid_q, instr_valid_d;
   logic              fetch_err_q, fetch_err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              consume_c;
   logic              issue_c;
   logic              timeout_c;
   logic              load_c;
   logic              misalign_c;
   logic [XLEN-1:0]   target_c;

   // Shared decode: handshake, request issue, timeout, accepted response, redirect target
   always_comb begin
      consume_c  = instr_valid_q & instr_ready;
      issue_c    = rst_n & (state_q == ST_RUN) & ~redirect & (~instr_valid_q | consume_c);
      timeout_c  = (state_q != ST_RUN) & ~imem_rvalid & (cnt_q >= CNT_W'(IMEM_MAX_LAT));
      load_c     = (state_q == ST_WAIT) & imem_rvalid & ~redirect;
      misalign_c = redirect & (redirect_target[1:0] != 2'b00);
      target_c   = {redirect_target[XLEN-1:2], 2'b00};
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; a response racing a redirect is dropped and the fetch restarts in RUN
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (issue_c) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (redirect) begin
               state_d = imem_rvalid ? ST_RUN : ST_FLUSH;
            end else if (imem_rvalid || timeout_c) begin
               state_d = ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (imem_rvalid || timeout_c) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // FSM outputs: request strobe plus next values of the fetch/output registers
   always_comb begin
      imem_req      = issue_c;
      imem_addr     = issue_c ? fetch_pc_q : '0;
      fetch_pc_d    = fetch_pc_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      fetch_err_d   = fetch_err_q | misalign_c | timeout_c;
      cnt_d         = ((state_q == ST_RUN) || (state_d == ST_RUN)) ? '0 : cnt_q + CNT_W'(1);
      if (redirect) begin
         fetch_pc_d    = target_c;
         instr_valid_d = 1'b0;
      end else if (load_c) begin
         instr_d       = imem_rdata;
         instr_pc_d    = fetch_pc_q;
         instr_valid_d = 1'b1;
         fetch_pc_d    = fetch_pc_q + XLEN'(4);
      end else if (consume_c) begin
         instr_valid_d = 1'b0;
      end
   end

   // Fetch PC, output register, sticky error and age counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc_q    <= RESET_PC;
         instr_q       <= NOP;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         fetch_err_q   <= 1'b0;
         cnt_q         <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         fetch_err_q   <= fetch_err_d;
         cnt_q         <= cnt_d;
      end
   end

   assign instr_valid = instr_valid_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign fetch_err   = fetch_err_q;

endmodule
